// File: rtl/multicycle_datapath.sv
// Multicycle datapath: five-state sequencer (FETCH/DECODE/EXEC/MEM/WB) with an
// 8-entry register file, external control unit and req/ack instruction/data memories.
`timescale 1ns/1ps

module multicycle_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned RST_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    input  logic              reg_dst,
    input  logic              alu_src,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              beq,
    input  logic              bne,
    input  logic              jump,
    input  logic [1:0]        alu_op,
    output logic [3:0]        opcode,
    output logic [PC_W-1:0]   pc_out,
    output logic              instr_done
);

    localparam int unsigned       JT_W   = (PC_W < 12) ? PC_W : 12;
    localparam logic [PC_W-1:0]   PC_RST = PC_W'(RST_PC);
    localparam logic [PC_W-1:0]   PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] D_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       beq;
        logic       bne;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [DATA_W-1:0] alu_f(
        input logic [1:0]        op,
        input logic [2:0]        fn,
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y
    );
        logic [DATA_W-1:0] r;
        case (op)
            2'b01: r = x - y;
            2'b10: begin
                case (fn)
                    3'b000:  r = x + y;
                    3'b001:  r = x - y;
                    3'b010:  r = x & y;
                    3'b011:  r = x | y;
                    3'b100:  r = ($signed(x) < $signed(y)) ? D_ONE : D_ZERO;
                    3'b101:  r = {x[DATA_W-2:0], 1'b0};
                    3'b110:  r = {1'b0, x[DATA_W-1:1]};
                    3'b111:  r = x ^ y;
                    default: r = x + y;
                endcase
            end
            default: r = x + y;
        endcase
        return r;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic              run_r;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_s;
    logic [15:0]       ir_r;
    ctrl_t             ctrl_r;
    ctrl_t             ctrl_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] mdr_r;
    logic [DATA_W-1:0] rf_r [0:7];
    logic [2:0]        rs_s;
    logic [2:0]        rt_s;
    logic [2:0]        rd_s;
    logic [2:0]        wsel_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] imm6_s;
    logic [PC_W-1:0]   off6_s;
    logic [PC_W-1:0]   jt_s;
    logic [DATA_W-1:0] op2_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] wdata_s;
    logic              zero_s;
    logic              taken_s;
    logic              done_s;

    assign rs_s      = ir_r[11:9];
    assign rt_s      = ir_r[8:6];
    assign rd_s      = ir_r[5:3];
    assign imm6_s    = {{(DATA_W-6){ir_r[5]}}, ir_r[5:0]};
    assign off6_s    = {{(PC_W-6){ir_r[5]}}, ir_r[5:0]};
    assign rs_val_s  = (rs_s == 3'd0) ? D_ZERO : rf_r[rs_s];
    assign rt_val_s  = (rt_s == 3'd0) ? D_ZERO : rf_r[rt_s];
    assign op2_s     = ctrl_r.alu_src ? imm6_s : b_r;
    assign alu_s     = alu_f(ctrl_r.alu_op, ir_r[2:0], a_r, op2_s);
    assign zero_s    = ((a_r - b_r) == D_ZERO);
    assign taken_s   = (ctrl_r.beq & zero_s) | (ctrl_r.bne & ~zero_s);
    assign wsel_s    = ctrl_r.reg_dst ? rd_s : rt_s;
    assign wdata_s   = ctrl_r.mem_to_reg ? mdr_r : alu_r;

    // Requests depend only on registered state, so reset clears them without a clock edge.
    assign imem_req   = run_r & (state_r == ST_FETCH);
    assign imem_addr  = pc_r;
    assign dmem_req   = (state_r == ST_MEM);
    assign dmem_we    = (state_r == ST_MEM) & ctrl_r.mem_write;
    assign dmem_addr  = alu_r;
    assign dmem_wdata = b_r;
    assign opcode     = ir_r[15:12];
    assign pc_out     = pc_r;
    assign instr_done = done_s;

    // Gather the control-unit strobes for latching at the end of DECODE.
    always_comb begin
        ctrl_s            = '0;
        ctrl_s.reg_dst    = reg_dst;
        ctrl_s.alu_src    = alu_src;
        ctrl_s.mem_to_reg = mem_to_reg;
        ctrl_s.reg_write  = reg_write;
        ctrl_s.mem_read   = mem_read;
        ctrl_s.mem_write  = mem_write;
        ctrl_s.beq        = beq;
        ctrl_s.bne        = bne;
        ctrl_s.jump       = jump;
        ctrl_s.alu_op     = alu_op;
    end

    // Jump target: IR[11:0] zero-extended or truncated to the PC width.
    always_comb begin
        jt_s             = '0;
        jt_s[JT_W-1:0]   = ir_r[JT_W-1:0];
    end

    // Next PC: jump beats a taken branch, which beats the sequential increment.
    always_comb begin
        pc_s = pc_r + PC_ONE;
        if (ctrl_r.jump) begin
            pc_s = jt_s;
        end else if (taken_s) begin
            pc_s = pc_r + PC_ONE + off6_s;
        end else begin
            pc_s = pc_r + PC_ONE;
        end
    end

    // Sequencer state register; run_r holds off the first fetch until one edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            run_r   <= 1'b1;
        end
    end

    // Sequencer next-state and retire pulse.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                if (ctrl_r.mem_read || ctrl_r.mem_write) begin
                    state_s = ST_MEM;
                end else if (ctrl_r.reg_write) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_FETCH;
                    done_s  = 1'b1;
                end
            end
            ST_MEM: begin
                // A store suppresses writeback even when mem_read is also set.
                if (!dmem_ack) begin
                    state_s = ST_MEM;
                end else if (ctrl_r.reg_write && ctrl_r.mem_read && !ctrl_r.mem_write) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_FETCH;
                    done_s  = 1'b1;
                end
            end
            ST_WB: begin
                state_s = ST_FETCH;
                done_s  = 1'b1;
            end
            default: state_s = ST_FETCH;
        endcase
    end

    // Per-state datapath registers: IR, latched control, operands, ALU result, PC, MDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= PC_RST;
            ir_r   <= 16'h0000;
            ctrl_r <= '0;
            a_r    <= D_ZERO;
            b_r    <= D_ZERO;
            alu_r  <= D_ZERO;
            mdr_r  <= D_ZERO;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir_r <= imem_rdata;
                    end
                end
                ST_DECODE: begin
                    ctrl_r <= ctrl_s;
                    a_r    <= rs_val_s;
                    b_r    <= rt_val_s;
                end
                ST_EXEC: begin
                    alu_r <= alu_s;
                    pc_r  <= pc_s;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        mdr_r <= dmem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file writeback; R0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= D_ZERO;
            end
        end else if ((state_r == ST_WB) && (wsel_s != 3'd0)) begin
            rf_r[wsel_s] <= wdata_s;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: memory/control-unit responders drive the DUT,
// expected retires and data accesses are queued up front and checked by a monitor.
`timescale 1ns/1ps

module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata = 8'h00;
    logic        dmem_ack = 1'b0;
    logic        reg_dst = 1'b0, alu_src = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, beq = 1'b0, bne = 1'b0, jump = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [3:0]  opcode;
    logic [7:0]  pc_out;
    logic        instr_done;

    multicycle_datapath #(.DATA_W(8), .PC_W(8), .RST_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .beq(beq), .bne(bne), .jump(jump),
        .alu_op(alu_op), .opcode(opcode), .pc_out(pc_out), .instr_done(instr_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0] faddr;
        int         len;
        logic [7:0] npc;
    } ret_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        int         cycles;
    } acc_t;

    ret_t        ret_q[$];
    acc_t        acc_q[$];
    logic [15:0] imem [0:255];
    logic [7:0]  dmem [0:255];
    int          checks = 0;
    int          errors = 0;
    bit          dmem_manual = 1'b0;
    bit          force_ack = 1'b0;
    bit          pc_pend = 1'b0;
    logic [7:0]  pc_exp = 8'h00;
    bit          in_instr = 1'b0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [7:0]  fetch_addr = 8'h00;
    int          req_cycles = 0;
    int          dcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ret(input logic [7:0] fa, input int len, input logic [7:0] npc);
        ret_t r;
        r.faddr = fa; r.len = len; r.npc = npc;
        ret_q.push_back(r);
    endtask

    task automatic push_acc(input logic we, input logic [7:0] a, input logic [7:0] wd, input int c);
        acc_t e;
        e.we = we; e.addr = a; e.wd = wd; e.cycles = c;
        acc_q.push_back(e);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic drain(input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (ret_q.size() == 0 && acc_q.size() == 0 && !pc_pend) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout with %0d retires and %0d accesses outstanding",
                 name, ret_q.size(), acc_q.size());
        finish_sim();
    endtask

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [5:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [2:0] fn);
        return {4'h0, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] enc_j(input logic [11:0] t);
        return {4'h5, t};
    endfunction

    // Memory and control-unit responders, driven just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        imem_ack   = imem_req;
        imem_rdata = imem[imem_addr];
        if (dmem_manual) begin
            dmem_ack = force_ack;
            dcnt     = 0;
        end else if (dmem_req) begin
            if (dcnt == ((dmem_addr == 8'h15) ? 3 : 0)) begin
                dmem_ack   = 1'b1;
                dmem_rdata = dmem[dmem_addr];
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                dcnt = 0;
            end else begin
                dmem_ack = 1'b0;
                dcnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end
        {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, beq, bne, jump} = 9'b0;
        alu_op = 2'b00;
        case (opcode)
            4'h0: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; end
            4'h1: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
            4'h2: begin alu_src = 1'b1; mem_write = 1'b1; end
            4'h3: begin beq = 1'b1; alu_op = 2'b01; end
            4'h4: begin bne = 1'b1; alu_op = 2'b01; end
            4'h5: jump = 1'b1;
            4'h6: begin alu_src = 1'b1; reg_write = 1'b1; end
            4'h7: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
                        mem_read = 1'b1; mem_write = 1'b1; end
            default: ;
        endcase
    end

    // Monitor: pops expectations on every data-access ack and every retire.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            in_instr   = 1'b0;
            pc_pend    = 1'b0;
            req_cycles = 0;
        end else begin
            if (pc_pend) begin
                chk("pc_after_retire", pc_out, pc_exp);
                pc_pend = 1'b0;
            end
            if (imem_req && !in_instr) begin
                in_instr   = 1'b1;
                start_cyc  = cyc;
                fetch_addr = imem_addr;
            end
            if (dmem_req) begin
                req_cycles++;
                if (acc_q.size() > 0) chk("dmem_addr_held", dmem_addr, acc_q[0].addr);
                if (dmem_ack) begin
                    if (acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dmem_unexpected: got access at %0h, expected none", dmem_addr);
                    end else begin
                        acc_t e;
                        e = acc_q.pop_front();
                        chk("dmem_we", dmem_we, e.we);
                        chk("dmem_req_cycles", req_cycles, e.cycles);
                        if (e.we) chk("dmem_wdata", dmem_wdata, e.wd);
                    end
                    req_cycles = 0;
                end
            end
            if (instr_done) begin
                if (ret_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL retire_unexpected: got retire of %0h, expected none", fetch_addr);
                end else begin
                    ret_t r;
                    r = ret_q.pop_front();
                    chk("fetch_addr", fetch_addr, r.faddr);
                    chk("retire_latency", cyc - start_cyc + 1, r.len);
                    pc_exp  = r.npc;
                    pc_pend = 1'b1;
                end
                in_instr = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    // Stimulus: program image, expected retires/accesses, and the reset scenarios.
    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 8'h00;
        end
        dmem[8'h10] = 8'h05; dmem[8'h11] = 8'h03; dmem[8'h12] = 8'hFF;
        dmem[8'h14] = 8'h80; dmem[8'h15] = 8'hA5;

        imem[0]  = 16'hF000;                     // nop
        imem[1]  = enc_i(4'h1, 3'd0, 3'd1, 6'h10); // lw  R1 <- 5
        imem[2]  = enc_i(4'h1, 3'd0, 3'd2, 6'h11); // lw  R2 <- 3
        imem[3]  = enc_r(3'd1, 3'd2, 3'd3, 3'b000); // add R3 = 8
        imem[4]  = enc_i(4'h2, 3'd0, 3'd3, 6'h18);
        imem[5]  = enc_r(3'd1, 3'd2, 3'd0, 3'b000); // add into R0
        imem[6]  = enc_i(4'h2, 3'd0, 3'd0, 6'h19);
        imem[7]  = enc_j(12'h00A);
        imem[9]  = enc_j(12'h00B);
        imem[10] = enc_i(4'h3, 3'd1, 3'd1, 6'h3E); // beq taken, -2
        imem[11] = enc_i(4'h4, 3'd1, 3'd1, 6'h3E); // bne not taken
        imem[12] = enc_i(4'h1, 3'd0, 3'd4, 6'h12); // R4 = FF
        imem[13] = enc_i(4'h6, 3'd0, 3'd5, 6'h01); // R5 = 1
        imem[14] = enc_r(3'd4, 3'd5, 3'd6, 3'b000); // FF+1 wraps
        imem[15] = enc_i(4'h2, 3'd0, 3'd6, 6'h1A);
        imem[16] = enc_i(4'h1, 3'd0, 3'd7, 6'h14); // R7 = 80
        imem[17] = enc_r(3'd7, 3'd5, 3'd6, 3'b100); // slt signed
        imem[18] = enc_i(4'h2, 3'd0, 3'd6, 6'h1B);
        imem[19] = enc_i(4'h1, 3'd0, 3'd6, 6'h15); // slow load
        imem[20] = enc_i(4'h2, 3'd0, 3'd6, 6'h1C);
        imem[21] = enc_i(4'h7, 3'd0, 3'd3, 6'h1D); // read+write+reg_write
        imem[22] = enc_i(4'h2, 3'd0, 3'd3, 6'h1E);
        imem[23] = enc_r(3'd1, 3'd2, 3'd6, 3'b111); // xor 5^3
        imem[24] = enc_i(4'h2, 3'd0, 3'd6, 6'h1F);
        imem[25] = enc_r(3'd2, 3'd1, 3'd6, 3'b001); // sub 3-5
        imem[26] = enc_i(4'h2, 3'd0, 3'd6, 6'h0F);
        imem[27] = enc_j(12'h040);

        push_ret(8'd0, 3, 8'd1);   push_ret(8'd1, 5, 8'd2);   push_ret(8'd2, 5, 8'd3);
        push_ret(8'd3, 4, 8'd4);   push_ret(8'd4, 4, 8'd5);   push_ret(8'd5, 4, 8'd6);
        push_ret(8'd6, 4, 8'd7);   push_ret(8'd7, 3, 8'd10);  push_ret(8'd10, 3, 8'd9);
        push_ret(8'd9, 3, 8'd11);  push_ret(8'd11, 3, 8'd12); push_ret(8'd12, 5, 8'd13);
        push_ret(8'd13, 4, 8'd14); push_ret(8'd14, 4, 8'd15); push_ret(8'd15, 4, 8'd16);
        push_ret(8'd16, 5, 8'd17); push_ret(8'd17, 4, 8'd18); push_ret(8'd18, 4, 8'd19);
        push_ret(8'd19, 8, 8'd20); push_ret(8'd20, 4, 8'd21); push_ret(8'd21, 4, 8'd22);
        push_ret(8'd22, 4, 8'd23); push_ret(8'd23, 4, 8'd24); push_ret(8'd24, 4, 8'd25);
        push_ret(8'd25, 4, 8'd26); push_ret(8'd26, 4, 8'd27); push_ret(8'd27, 3, 8'h40);
        push_ret(8'h40, 3, 8'h41);

        push_acc(1'b0, 8'h10, 8'h00, 1); push_acc(1'b0, 8'h11, 8'h00, 1);
        push_acc(1'b1, 8'h18, 8'h08, 1); push_acc(1'b1, 8'h19, 8'h00, 1);
        push_acc(1'b0, 8'h12, 8'h00, 1); push_acc(1'b1, 8'h1A, 8'h00, 1);
        push_acc(1'b0, 8'h14, 8'h00, 1); push_acc(1'b1, 8'h1B, 8'h01, 1);
        push_acc(1'b0, 8'h15, 8'h00, 4); push_acc(1'b1, 8'h1C, 8'hA5, 1);
        push_acc(1'b1, 8'h1D, 8'h08, 1); push_acc(1'b1, 8'h1E, 8'h08, 1);
        push_acc(1'b1, 8'h1F, 8'h06, 1); push_acc(1'b1, 8'h0F, 8'hFE, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_instr_done", instr_done, 1'b0);
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_opcode", opcode, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_before_first_edge", imem_req, 1'b0);
        @(posedge clk); #2;
        chk("req_after_first_edge", imem_req, 1'b1);
        chk("first_fetch_addr", imem_addr, 8'h00);

        drain(600, "program_drain");

        // Reset in the middle of the fetch of 0x41.
        chk("midfetch_req", imem_req, 1'b1);
        chk("midfetch_addr", imem_addr, 8'h41);
        rst_n = 1'b0;
        #1;
        chk("midfetch_rst_req", imem_req, 1'b0);
        chk("midfetch_rst_pc", pc_out, 8'h00);

        // Restart into a store whose ack never comes, then reset during MEM.
        imem[0]    = enc_j(12'h030);
        imem[8'h30] = enc_i(4'h2, 3'd0, 3'd0, 6'h17);
        dmem_manual = 1'b1;
        force_ack   = 1'b0;
        push_ret(8'h00, 3, 8'h30);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk); #1;
                if (dmem_req) seen = 1'b1;
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL mem_wait: got no dmem_req within 50 cycles, expected one");
                finish_sim();
            end
        end
        repeat (2) @(negedge clk);
        #1;
        chk("mem_stall_req", dmem_req, 1'b1);
        chk("mem_stall_we", dmem_we, 1'b1);
        chk("mem_stall_addr", dmem_addr, 8'h17);
        rst_n = 1'b0;
        #1;
        chk("mem_rst_req", dmem_req, 1'b0);
        chk("mem_rst_we", dmem_we, 1'b0);
        chk("mem_rst_pc", pc_out, 8'h00);

        // Late data ack after reset must not disturb the next instruction.
        imem[0]   = 16'hF000;
        force_ack = 1'b1;
        push_ret(8'h00, 3, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("late_ack_pc", pc_out, 8'h00);
        chk("late_ack_dmem_req", dmem_req, 1'b0);
        @(negedge clk); #1;
        force_ack   = 1'b0;
        dmem_manual = 1'b0;
        drain(50, "late_ack_drain");
        rst_n = 1'b0;
        finish_sim();
    end

endmodule
